// File: rtl/ecg_dp_bram.sv
// ecg_dp_bram: true dual-port block RAM with per-byte write enables,
// selectable read latency (1 or 2), selectable read-during-write
// behaviour, same-address write collision flag and a sweeping clear
// engine that zeroes the whole array after reset or on request.
module ecg_dp_bram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1,
  parameter int WR_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    ena,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  output logic [DATA_WIDTH-1:0]   douta,
  output logic                    valida,
  input  logic                    enb,
  input  logic [DATA_WIDTH/8-1:0] web,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   dinb,
  output logic [DATA_WIDTH-1:0]   doutb,
  output logic                    validb,
  output logic                    collision
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int          CW    = ADDR_WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         clr_cnt;
  logic                  clr_last;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  a_en, b_en, a_wr, b_wr, coll_now;
  logic [NB-1:0]         b_we_eff;
  logic [DATA_WIDTH-1:0] rda, rdb;
  logic [DATA_WIDTH-1:0] da_s1, db_s1;
  logic                  va_s1, vb_s1;

  assign busy     = (state == CLEAR);
  assign clr_last = (clr_cnt == CW'(DEPTH - 1));

  // Ports are locked out for the whole clear sweep.
  assign a_en     = ena & ~busy;
  assign b_en     = enb & ~busy;
  assign a_wr     = a_en & (|wea);
  assign b_wr     = b_en & (|web);
  assign coll_now = a_wr & b_wr & (addra == addrb);

  // Port A owns any byte both ports write at the same address.
  assign b_we_eff = (a_en && (addra == addrb)) ? (web & ~wea) : web;

  // Clear FSM state register; reset parks the FSM in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  // Clear FSM next state: one sweep per request, requests ignored mid-sweep.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_req) state_nxt = CLEAR;
      CLEAR:   if (clr_last)  state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Sweep address counter, back to 0 when the sweep finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
    else                     clr_cnt <= '0;
  end

  // Storage array: sweep zeroing, else byte-masked port writes.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (a_en && wea[i]) mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
        if (b_en && b_we_eff[i]) mem[addrb][i*8 +: 8] <= dinb[i*8 +: 8];
      end
    end
  end

  // Read word per port: stored data, with own write bytes in write-first mode.
  always_comb begin
    rda = mem[addra];
    rdb = mem[addrb];
    if (WR_MODE == 1) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wea[i]) rda[i*8 +: 8] = dina[i*8 +: 8];
        if (web[i]) rdb[i*8 +: 8] = dinb[i*8 +: 8];
      end
    end
  end

  // First read stage and collision flag; data holds while the port is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_s1     <= '0;
      db_s1     <= '0;
      va_s1     <= 1'b0;
      vb_s1     <= 1'b0;
      collision <= 1'b0;
    end else begin
      va_s1     <= a_en;
      vb_s1     <= b_en;
      collision <= coll_now;
      if (a_en) da_s1 <= rda;
      if (b_en) db_s1 <= rdb;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] da_s2, db_s2;
    logic                  va_s2, vb_s2;

    // Second read stage: data advances only together with its valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        da_s2 <= '0;
        db_s2 <= '0;
        va_s2 <= 1'b0;
        vb_s2 <= 1'b0;
      end else begin
        va_s2 <= va_s1;
        vb_s2 <= vb_s1;
        if (va_s1) da_s2 <= da_s1;
        if (vb_s1) db_s2 <= db_s1;
      end
    end

    assign douta  = da_s2;
    assign doutb  = db_s2;
    assign valida = va_s2;
    assign validb = vb_s2;
  end else begin : g_lat1
    assign douta  = da_s1;
    assign doutb  = db_s1;
    assign valida = va_s1;
    assign validb = vb_s1;
  end

endmodule

// File: tb/tb_ecg_dp_bram.sv
// Bench for ecg_dp_bram: two instances (latency 1 / read-first and
// latency 2 / write-first) share one stimulus stream; a word-level memory
// model predicts read results, which a negedge monitor checks in order.
module tb_ecg_dp_bram;

  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk, rst_n, clear_req;
  logic        ena, enb;
  logic [3:0]  wea, web, addra, addrb;
  logic [31:0] dina, dinb;
  logic        busy0, valida0, validb0, coll0;
  logic        busy1, valida1, validb1, coll1;
  logic [31:0] douta0, doutb0, douta1, doutb1;

  int          checks = 0;
  int          failures = 0;
  int          ecount = 0;
  int          busy_left = 0;
  bit          mon_on = 0;
  logic [31:0] mem_m [DEPTH];
  exp_t        qa0[$], qb0[$], qa1[$], qb1[$];
  int          cq0[$], cq1[$];

  ecg_dp_bram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(1), .WR_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy0),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .valida(valida0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .validb(validb0),
    .collision(coll0));

  ecg_dp_bram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2), .WR_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .valida(valida1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .validb(validb1),
    .collision(coll1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecount <= ecount + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return qa0.size();
      1: return qb0.size();
      2: return qa1.size();
      default: return qb1.size();
    endcase
  endfunction

  function automatic exp_t qpeek(input int id);
    case (id)
      0: return qa0[0];
      1: return qb0[0];
      2: return qa1[0];
      default: return qb1[0];
    endcase
  endfunction

  function automatic exp_t qpop(input int id);
    case (id)
      0: return qa0.pop_front();
      1: return qb0.pop_front();
      2: return qa1.pop_front();
      default: return qb1.pop_front();
    endcase
  endfunction

  task automatic mon_port(input int id, input logic v, input logic [31:0] d, input string name);
    exp_t e;
    if (v === 1'b1) begin
      checks++;
      if (qsize(id) == 0) begin
        failures++;
        $display("FAIL %s: unexpected valid at edge %0d data %h, expected no read", name, ecount, d);
      end else begin
        e = qpop(id);
        if (e.due != ecount || e.data !== d) begin
          failures++;
          $display("FAIL %s: got %h at edge %0d expected %h at edge %0d", name, d, ecount, e.data, e.due);
        end
      end
    end else if (qsize(id) > 0) begin
      e = qpeek(id);
      if (e.due < ecount) begin
        checks++;
        failures++;
        e = qpop(id);
        $display("FAIL %s: no valid at edge %0d expected %h", name, e.due, e.data);
      end
    end
  endtask

  task automatic mon_coll(input int id, input logic c);
    int n, due;
    n = (id == 0) ? cq0.size() : cq1.size();
    if (c === 1'b1) begin
      checks++;
      if (n == 0) begin
        failures++;
        $display("FAIL collision%0d: got pulse at edge %0d expected none", id, ecount);
      end else begin
        due = (id == 0) ? cq0.pop_front() : cq1.pop_front();
        if (due != ecount) begin
          failures++;
          $display("FAIL collision%0d: got pulse at edge %0d expected edge %0d", id, ecount, due);
        end
      end
    end else if (n > 0) begin
      due = (id == 0) ? cq0[0] : cq1[0];
      if (due < ecount) begin
        checks++;
        failures++;
        due = (id == 0) ? cq0.pop_front() : cq1.pop_front();
        $display("FAIL collision%0d: got no pulse expected pulse at edge %0d", id, due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      mon_port(0, valida0, douta0, "dut0.porta");
      mon_port(1, validb0, doutb0, "dut0.portb");
      mon_port(2, valida1, douta1, "dut1.porta");
      mon_port(3, validb1, doutb1, "dut1.portb");
      mon_coll(0, coll0);
      mon_coll(1, coll1);
    end
  end

  // One clock of stimulus; the model predicts what that edge does.
  task automatic drive(input bit ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                       input bit eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db,
                       input bit clr);
    exp_t e;
    logic [3:0] wbm;
    checks++;
    if (busy0 !== (busy_left > 0) || busy1 !== (busy_left > 0)) begin
      failures++;
      $display("FAIL busy: got dut0=%b dut1=%b expected %b", busy0, busy1, busy_left > 0);
    end
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    clear_req = clr;
    if (busy_left > 0) begin
      mem_m[DEPTH - busy_left] = '0;
      busy_left--;
    end else begin
      if (ea) begin
        e.data = mem_m[aa];                 e.due = ecount + 1; qa0.push_back(e);
        e.data = merge(mem_m[aa], da, wa);  e.due = ecount + 2; qa1.push_back(e);
      end
      if (eb) begin
        e.data = mem_m[ab];                 e.due = ecount + 1; qb0.push_back(e);
        e.data = merge(mem_m[ab], db, wb);  e.due = ecount + 2; qb1.push_back(e);
      end
      if (ea && (|wa) && eb && (|wb) && aa == ab) begin
        cq0.push_back(ecount + 1);
        cq1.push_back(ecount + 1);
      end
      wbm = (ea && aa == ab) ? (wb & ~wa) : wb;
      if (ea) mem_m[aa] = merge(mem_m[aa], da, wa);
      if (eb) mem_m[ab] = merge(mem_m[ab], db, wbm);
      if (clr) busy_left = DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0, 0);
  endtask

  // Counts busy cycles; optionally hammers ports and clear_req meanwhile.
  task automatic wait_sweep(input string name, input bit hammer);
    int n;
    n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      if (hammer) drive(1, 4'hF, 4'($urandom), $urandom, 1, 4'hF, 4'($urandom), $urandom, 1);
      else        idle(1);
      n++;
    end
    chk(name, n, 16);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++)
      drive(1, 4'h0, 4'(a), $urandom, 1, 4'h0, 4'(DEPTH - 1 - a), $urandom, 0);
    idle(3);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, " douta0"}, douta0, 32'h0);
    chk({tag, " doutb1"}, doutb1, 32'h0);
    chk({tag, " valids"}, {28'h0, valida0, validb0, valida1, validb1}, 32'h0);
    chk({tag, " collision"}, {30'h0, coll0, coll1}, 32'h0);
    chk({tag, " busy"}, {30'h0, busy0, busy1}, 32'h3);
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0;
    ena = 1'b0; wea = '0; addra = '0; dina = '0;
    enb = 1'b0; web = '0; addrb = '0; dinb = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    reset_outputs_zero("reset");
    rst_n = 1'b1;
    busy_left = DEPTH;
    mon_on = 1'b1;
    wait_sweep("busy cycles after reset", 0);
    read_all();

    // Byte-enable merge on addr3, then hold with port idle.
    drive(1, 4'hF, 4'd3, 32'hAABBCCDD, 0, 4'h0, 4'h0, 32'h0, 0);
    drive(1, 4'b0010, 4'd3, 32'h00001100, 0, 4'h0, 4'h0, 32'h0, 0);
    drive(1, 4'h0, 4'd3, 32'h0, 0, 4'h0, 4'h0, 32'h0, 0);
    idle(3);
    chk("addr3 merged hold dut0", douta0, 32'hAABB11DD);
    chk("addr3 merged hold dut1", douta1, 32'hAABB11DD);

    // Same-address dual write: port A wins, one collision pulse.
    drive(1, 4'hF, 4'd5, 32'h11111111, 1, 4'hF, 4'd5, 32'h22222222, 0);
    drive(0, 4'h0, 4'd0, 32'h0, 1, 4'h0, 4'd5, 32'h0, 0);
    idle(3);
    chk("addr5 after collision dut0", doutb0, 32'h11111111);
    chk("addr5 after collision dut1", doutb1, 32'h11111111);

    // Read-during-write: read-first returns old, write-first returns new.
    drive(1, 4'hF, 4'd7, 32'h9, 0, 4'h0, 4'h0, 32'h0, 0);
    drive(1, 4'hF, 4'd7, 32'h5, 0, 4'h0, 4'h0, 32'h0, 0);
    idle(3);
    chk("addr7 read-first", douta0, 32'h9);
    chk("addr7 write-first", douta1, 32'h5);

    // Randomized traffic, addresses biased toward collisions.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) ? 4'($urandom) : 4'h0,
            $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) ? 4'($urandom) : 4'h0,
            $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom), $urandom,
            $urandom_range(0, 149) == 0);
    end
    for (int i = 0; i < 40 && busy0 === 1'b1; i++) idle(1);
    read_all();

    // Clear request with ports and clear_req hammered during the sweep.
    drive(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0, 1);
    wait_sweep("busy cycles with clear_req during sweep", 1);
    read_all();

    // Reset in the middle of a sweep restarts it from address 0.
    drive(1, 4'hF, 4'd15, 32'hDEADBEEF, 1, 4'hF, 4'd9, 32'hCAFEF00D, 0);
    drive(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0, 1);
    idle(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_outputs_zero("mid-sweep reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    busy_left = DEPTH;
    wait_sweep("busy cycles after mid-sweep reset", 0);
    read_all();

    idle(4);
    chk("scoreboard drained", 32'(qa0.size() + qb0.size() + qa1.size() + qb1.size()
                                  + cq0.size() + cq1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ecg_dp_bram.md
ECG_DP_BRAM -- requirements
Module: ecg_dp_bram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter WR_MODE, default 0, read-during-write on the same port; 0 = read-first (old data), 1 = write-first (new data).
REQ-005 SHALL have ports: clk  in  1  clock, all logic on rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: clear_req  in  1  pulse to zero the whole array; busy  out  1  clear engine running.
REQ-007 SHALL have ports: ena  in  1  port A enable; wea  in  NB = DATA_WIDTH/8  byte write enables; addra  in  ADDR_WIDTH  address; dina  in  DATA_WIDTH  write data.
REQ-008 SHALL have ports: douta  out  DATA_WIDTH  read data; valida  out  1  douta holds a new read result.
REQ-009 SHALL have ports enb, web, addrb, dinb, doutb, validb for port B, with the same widths and meanings as port A.
REQ-010 SHALL have port: collision  out  1  one-cycle pulse on a same-address write conflict.

Function
REQ-011 SHALL treat an enabled port with any byte-enable bit set as a write; only bytes whose enable bit is 1 SHALL be updated.
REQ-012 SHALL treat every enabled port cycle as a read, including write cycles; the read returns data per WR_MODE for the enabled bytes and stored data for the other bytes.
REQ-013 SHALL present read data RD_LATENCY cycles after the enable cycle, and SHALL assert valid for exactly one cycle alongside it; for RD_LATENCY=2, valid and data SHALL share one pipeline.
REQ-014 SHALL hold dout at its last value when the port is disabled; dout SHALL NOT be cleared to 0.
REQ-015 SHALL write only port A's bytes when both ports write the same address in the same cycle with overlapping byte enables; port B's non-overlapping bytes SHALL still be written.
REQ-016 SHALL pulse collision for one cycle, on the edge after the conflicting cycle, for any same-address write conflict.
REQ-017 SHALL return the pre-edge stored word on a port that reads an address the other port writes in the same cycle; cross-port data SHALL never be forwarded.
REQ-018 SHALL implement a clear FSM with states IDLE and CLEAR.
REQ-019 SHALL move IDLE -> CLEAR on clear_req=1; in CLEAR it SHALL write 0 to one address per cycle, from 0 to DEPTH-1, then return to IDLE.
REQ-020 SHALL keep busy = (state==CLEAR).
REQ-021 SHALL ignore ena, enb, wea and web while busy=1: no memory update from the ports and no valid pulses.
REQ-022 SHALL ignore clear_req while in CLEAR; the sweep SHALL NOT restart.
REQ-023 SHALL wrap the clear counter to 0 on exit from CLEAR; the counter SHALL be ADDR_WIDTH+1 bits so DEPTH-1 is detected without overflow.

Reset
REQ-024 SHALL, while rst_n=0, force douta=0, doutb=0, valida=0, validb=0 and collision=0, clear the latency pipeline, and zero the clear counter, all asynchronously.
REQ-025 SHALL place the FSM in CLEAR during reset, so busy=1 during reset and for DEPTH cycles after rst_n rises.
REQ-026 SHALL, on reset asserted mid-sweep, abort the sweep and restart it from address 0 after release.

Verification (bench: DATA_WIDTH=32, ADDR_WIDTH=4, DEPTH=16)
REQ-027 SHALL verify: release rst_n -> busy=1 for exactly 16 cycles, then 0; a read of any address returns 0x00000000.
REQ-028 SHALL verify: write A addr3=0xAABBCCDD with wea=1111, then wea=0010 with dina=0x00001100 -> a subsequent read of addr3 returns 0xAABB11DD.
REQ-029 SHALL verify: with RD_LATENCY=2 and a read at cycle t -> valida=1 and douta valid at cycle t+2 only; douta holds the value while ena=0.
REQ-030 SHALL verify: same-cycle writes A=0x11111111 and B=0x22222222 to addr5 with all byte enables -> addr5=0x11111111 and one collision pulse.
REQ-031 SHALL verify: a write to addr7 of 0x5 over a stored 0x9, run with WR_MODE=0 and with WR_MODE=1 -> the same-cycle read returns 0x9 and 0x5 respectively.
REQ-032 SHALL verify: clear_req issued while busy and port writes issued during CLEAR -> no restart, no memory change from the ports, and all 16 words are 0 at the end.
